// File: rtl/cpu_controller_mc.sv
// cpu_controller_mc: multi-cycle CPU control FSM.
// Sequences FETCH/DECODE/EXEC/MEM for each instruction and drives the
// datapath strobes. It supports conditional branches on datapath flags, a
// configurable data-memory latency, HALT, and trapping of illegal opcodes.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset (overrides en)
//   en                  run enable; 0 holds all state and forces strobes low
//   opcode[OPW-1:0]     opcode field from the instruction register
//   za, zb, eq, gt, lt  datapath flags (gt/lt reserved, ignored)
//   loadA..selB         datapath / data-memory strobes (combinational)
//   halted              FSM is in HALT
//   illegal             sticky: HALT was entered on an illegal opcode
module cpu_controller_mc #(
    parameter int unsigned OPW     = 4,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned CNTW    = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [OPW-1:0] opcode,
    input  logic           za,
    input  logic           zb,
    input  logic           eq,
    input  logic           gt,
    input  logic           lt,
    output logic           loadA,
    output logic           loadB,
    output logic           loadC,
    output logic           loadIR,
    output logic           loadPC,
    output logic           incPC,
    output logic           mode,
    output logic           we_DM,
    output logic           selA,
    output logic           selB,
    output logic           halted,
    output logic           illegal
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [3:0] OP_LDA  = 4'b0100;
    localparam logic [3:0] OP_LDB  = 4'b0101;
    localparam logic [3:0] OP_STC  = 4'b0110;
    localparam logic [3:0] OP_JMP  = 4'b0111;
    localparam logic [3:0] OP_BZA  = 4'b1100;
    localparam logic [3:0] OP_BZB  = 4'b1101;
    localparam logic [3:0] OP_BEQ  = 4'b1110;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(MEM_LAT - 1);

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              illegal_q, illegal_d;
    logic              illegal_op_c;

    // gt/lt are reserved for a later generation
    logic unused_flags;
    assign unused_flags = gt ^ lt;

    // Any set bit above [3:0] makes the opcode illegal (always 0 when OPW == 4)
    assign illegal_op_c = (opcode >> 4) != '0;

    // State register and datapath of the controller; en=0 freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RESET;
            op_q      <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else if (en) begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                op_d = opcode[3:0];
                if (illegal_op_c) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_LDA, OP_LDB, OP_STC: begin
                        cnt_d   = CNT_LOAD;
                        state_d = S_MEM;
                    end
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (cnt_q == '0) begin
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_RESET;
        endcase
    end

    // Output decode; strobes are gated by en, status outputs are not
    always_comb begin
        loadA   = 1'b0;
        loadB   = 1'b0;
        loadC   = 1'b0;
        loadIR  = 1'b0;
        loadPC  = 1'b0;
        incPC   = 1'b0;
        mode    = 1'b0;
        we_DM   = 1'b0;
        selA    = 1'b0;
        selB    = 1'b0;
        halted  = (state_q == S_HALT);
        illegal = illegal_q;
        if (en) begin
            case (state_q)
                S_FETCH: begin
                    loadIR = 1'b1;
                    incPC  = 1'b1;
                end
                S_EXEC: begin
                    // op_q[2]==0 covers both ALU groups; op_q[3] picks the mode
                    if (!op_q[2]) begin
                        loadC = 1'b1;
                        mode  = op_q[3];
                    end else begin
                        case (op_q)
                            OP_JMP: loadPC = 1'b1;
                            OP_BZA: loadPC = za;
                            OP_BZB: loadPC = zb;
                            OP_BEQ: loadPC = eq;
                            default: loadPC = 1'b0;
                        endcase
                        selA = loadPC;
                        selB = loadPC;
                    end
                end
                S_MEM: begin
                    if (cnt_q == '0) begin
                        loadA = (op_q == OP_LDA);
                        loadB = (op_q == OP_LDB);
                        we_DM = (op_q == OP_STC);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
